unsigned_mac_seq_v: RTL and testbench

Sequential, width-parametrised unsigned multiply-accumulate calculator: computes o_fu = i_au * i_bu + i_cu using a shift-add datapath, one multiplier bit per clock. It is the next generation of the team's combinational unsigned calculator. Operands are captured under a start/done handshake, and the result is held until the next operation. It sits as a leaf arithmetic block under a controller that issues one operation at a time.

---
 rtl/unsigned_mac_seq_v.sv | 101 ++++++++++
 tb/tb_unsigned_mac_seq_v.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_mac_seq_v.sv
// Sequential unsigned multiply-accumulate: o_fu = a * b + c, computed by shift-add,
// one multiplier bit per clock, behind a start/busy/done handshake.
module unsigned_mac_seq_v #(
    parameter int W = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [W-1:0]   i_au,
    input  logic [W-1:0]   i_bu,
    input  logic [W-1:0]   i_cu,
    output logic [2*W-1:0] o_fu,
    output logic           o_busy,
    output logic           o_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [2*W-1:0]  fu_q, fu_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  sum;
    logic            last_iter;

    // The single 2W-bit adder: partial product for the current multiplier bit.
    always_comb begin
        addend    = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
        sum       = acc_q + addend;
        last_iter = (cnt_q == CW'(W - 1));
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        fu_d    = fu_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    a_d     = i_au;
                    b_d     = i_bu;
                    acc_d   = {{W{1'b0}}, i_cu};
                    cnt_d   = '0;
                    state_d = S_MUL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    fu_d    = sum;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            fu_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            fu_q    <= fu_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode the state register only, so nothing passes combinationally from inputs.
    assign o_fu   = fu_q;
    assign o_busy = (state_q == S_MUL);
    assign o_done = (state_q == S_DONE);

endmodule

// File: tb/tb_unsigned_mac_seq_v.sv
// Directed bench for unsigned_mac_seq_v: a W=4 instance for handshake and corner
// behaviour, and a W=8 instance for the wide corner case and a random sweep.
module tb_unsigned_mac_seq_v;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst4, start4;
    logic [3:0] a4, b4, c4;
    logic [7:0] fu4;
    logic       busy4, done4;

    logic        rst8, start8;
    logic [7:0]  a8, b8, c8;
    logic [15:0] fu8;
    logic        busy8, done8;

    int tests = 0;
    int fails = 0;

    unsigned_mac_seq_v #(.W(4)) dut4 (
        .i_clk(clk), .i_rst(rst4), .i_start(start4),
        .i_au(a4), .i_bu(b4), .i_cu(c4),
        .o_fu(fu4), .o_busy(busy4), .o_done(done4)
    );

    unsigned_mac_seq_v #(.W(8)) dut8 (
        .i_clk(clk), .i_rst(rst8), .i_start(start8),
        .i_au(a8), .i_bu(b8), .i_cu(c8),
        .o_fu(fu8), .o_busy(busy8), .o_done(done8)
    );

    // One W=4 operation; sample k is the k-th falling edge after the start edge.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       output int lat, output int busy_cnt, output int done_cnt,
                       output logic [7:0] fu);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = -1; busy_cnt = 0; done_cnt = 0; fu = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy4) busy_cnt++;
            if (done4) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k - 1;
                    fu  = fu4;
                end
            end
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       output int lat, output logic [15:0] fu);
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = -1; fu = '0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (done8) begin
                lat = k - 1;
                fu  = fu8;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst4 = 1'b1; rst8 = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; c4 = '0; a8 = '0; b8 = '0; c8 = '0;
        #3;
        tests++;
        if (fu4 !== 8'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_w4: fu=%0d busy=%b done=%b expected 0/0/0", fu4, busy4, done4);
        end
        tests++;
        if (fu8 !== 16'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL reset_w8: fu=%0d busy=%b done=%b expected 0/0/0", fu8, busy8, done8);
        end
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0; rst8 = 1'b0;
    endtask

    task automatic test_basic;
        int lat, bc, dc;
        logic [7:0] fu;
        op4(4'd3, 4'd4, 4'd5, lat, bc, dc, fu);
        tests++;
        if (fu !== 8'd17) begin
            fails++; $display("FAIL basic_fu: got %0d expected 17", fu);
        end
        tests++;
        if (lat !== 4) begin
            fails++; $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        tests++;
        if (bc !== 4) begin
            fails++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc);
        end
        tests++;
        if (dc !== 1) begin
            fails++; $display("FAIL basic_done_pulses: got %0d expected 1", dc);
        end
    endtask

    task automatic test_corners;
        logic [3:0] va [3] = '{4'd15, 4'd9, 4'd0};
        logic [3:0] vb [3] = '{4'd15, 4'd0, 4'd0};
        logic [3:0] vc [3] = '{4'd15, 4'd9, 4'd0};
        logic [7:0] ve [3] = '{8'd240, 8'd9, 8'd0};
        int lat, bc, dc;
        logic [7:0] fu;
        for (int i = 0; i < 3; i++) begin
            op4(va[i], vb[i], vc[i], lat, bc, dc, fu);
            tests++;
            if (fu !== ve[i] || dc !== 1 || lat !== 4) begin
                fails++;
                $display("FAIL corner_%0d: fu=%0d done_pulses=%0d lat=%0d expected fu=%0d pulses=1 lat=4",
                         i, fu, dc, lat, ve[i]);
            end
        end
    endtask

    task automatic test_ignored_start;
        int dc = 0;
        logic [7:0] fu = '0;
        @(negedge clk);
        a4 = 4'd2; b4 = 4'd7; c4 = 4'd1; start4 = 1'b1;
        @(negedge clk);                 // k=1
        start4 = 1'b0;
        @(negedge clk);                 // k=2, inside MUL
        a4 = 4'd15; b4 = 4'd15; c4 = 4'd15; start4 = 1'b1;
        for (int k = 3; k <= 20; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
                if (dc == 0) fu = fu4;
                dc++;
            end
        end
        tests++;
        if (fu !== 8'd15) begin
            fails++; $display("FAIL ignored_start_fu: got %0d expected 15", fu);
        end
        tests++;
        if (dc !== 1) begin
            fails++; $display("FAIL ignored_start_done_pulses: got %0d expected 1", dc);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a4 = ~a4; b4 = b4 + 4'd3; c4 = c4 ^ 4'b0101;
            tests++;
            if (fu4 !== 8'd15 || done4 !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: fu=%0d done=%b expected fu=15 done=0", i, fu4, done4);
            end
        end
    endtask

    task automatic test_back_to_back;
        int dcount = 0;
        int dk [2] = '{-1, -1};
        logic [7:0] dfu [2] = '{8'd0, 8'd0};
        logic busy_at6 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd1; c4 = 4'd0; start4 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a4 = 4'd5; b4 = 4'd6; c4 = 4'd3;
            end
            if (k == 6) begin
                start4   = 1'b0;
                busy_at6 = busy4;
            end
            if (done4) begin
                if (dcount < 2) begin
                    dk[dcount]  = k;
                    dfu[dcount] = fu4;
                end
                dcount++;
            end
        end
        tests++;
        if (dcount !== 2) begin
            fails++; $display("FAIL b2b_done_pulses: got %0d expected 2", dcount);
        end
        tests++;
        if (dfu[0] !== 8'd1 || dfu[1] !== 8'd33) begin
            fails++; $display("FAIL b2b_results: got %0d,%0d expected 1,33", dfu[0], dfu[1]);
        end
        tests++;
        if (dk[1] - dk[0] !== 5) begin
            fails++; $display("FAIL b2b_spacing: got %0d expected 5", dk[1] - dk[0]);
        end
        tests++;
        if (busy_at6 !== 1'b1) begin
            fails++; $display("FAIL b2b_busy_after_done: got %b expected 1", busy_at6);
        end
    endtask

    task automatic test_reset_mid;
        int dc = 0;
        int lat, bc;
        logic [7:0] fu;
        @(negedge clk);
        a4 = 4'd15; b4 = 4'd15; c4 = 4'd0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        #2 rst4 = 1'b1;
        #1;
        tests++;
        if (fu4 !== 8'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: fu=%0d busy=%b done=%b expected 0/0/0", fu4, busy4, done4);
        end
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done4) dc++;
        end
        tests++;
        if (dc !== 0) begin
            fails++; $display("FAIL reset_mid_no_done: got %0d pulses expected 0", dc);
        end
        op4(4'd2, 4'd3, 4'd4, lat, bc, dc, fu);
        tests++;
        if (fu !== 8'd10 || lat !== 4) begin
            fails++; $display("FAIL reset_recovery: fu=%0d lat=%0d expected fu=10 lat=4", fu, lat);
        end
    endtask

    task automatic test_w8;
        int lat;
        logic [15:0] fu, exp_fu;
        logic [7:0] a, b, c;
        int sweep_fails = 0;
        op8(8'd255, 8'd255, 8'd255, lat, fu);
        tests++;
        if (fu !== 16'd65280 || lat !== 8) begin
            fails++; $display("FAIL w8_max: fu=%0d lat=%0d expected fu=65280 lat=8", fu, lat);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            exp_fu = 16'(a) * 16'(b) + 16'(c);
            op8(a, b, c, lat, fu);
            tests++;
            if (fu !== exp_fu || lat !== 8) begin
                fails++;
                sweep_fails++;
                if (sweep_fails <= 10)
                    $display("FAIL w8_sweep_%0d: a=%0d b=%0d c=%0d got %0d lat=%0d expected %0d lat=8",
                             i, a, b, c, fu, lat, exp_fu);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corners;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        test_w8;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
